fetch_db_line_rd: RTL and testbench

- Read sequencer directly downstream of the deblocking line buffer (the block-in/line-out bank memory, 208 x 32-pixel lines).
- After one LCU has been written, it walks the buffer's read port in line order: current luma, then interleaved UV, then optionally the top-neighbour lines.
- It captures each 32-pixel line and streams it to the store/DDR-write stage over a valid/ready interface.
- A small credit-checked FIFO absorbs backpressure, so no read is ever lost.

---
 rtl/fetch_db_line_rd_pkg.sv | 28 ++
 rtl/fetch_db_skid_fifo.sv | 56 +++++
 rtl/fetch_db_line_rd.sv | 135 +++++++++++++
 tb/tb_fetch_db_line_rd.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_db_line_rd_pkg.sv
// Shared encoder constants for the deblocking line-buffer read sequencer.
package fetch_db_line_rd_pkg;

  localparam int unsigned ENC_PIXEL_WIDTH = 8;
  localparam int unsigned LINE_PIXELS     = 32;

  // Region base addresses inside the 208-line deblocking buffer
  localparam int unsigned LUMA_BASE   = 0;
  localparam int unsigned CHROMA_BASE = 128;
  localparam int unsigned TOP_BASE    = 192;

  // Region tag carried with every output beat
  typedef enum logic [1:0] {
    SEL_LUMA   = 2'd0,
    SEL_CHROMA = 2'd1,
    SEL_TOP    = 2'd2
  } sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LUMA,
    ST_CHROMA,
    ST_TOP,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/fetch_db_skid_fifo.sv
// Small synchronous FIFO holding {last, sel, data} beats; push and pop may
// coincide when full or empty.
module fetch_db_skid_fifo #(
  parameter int unsigned WIDTH = 259,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is only taken when the head leaves the same cycle
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop_ok) rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_db_line_rd.sv
// Walks the deblocking line buffer in region order (luma, UV, optional top)
// and streams each 32-pixel line downstream through a credit-checked FIFO.
module fetch_db_line_rd
  import fetch_db_line_rd_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH  = ENC_PIXEL_WIDTH,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned LUMA_LINES   = 128,
  parameter int unsigned CHROMA_LINES = 64,
  parameter int unsigned TOP_LINES    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic                            top_en_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            ren_o,
  output logic [7:0]                      raddr_o,
  input  logic [PIXEL_WIDTH*LINE_PIXELS-1:0] rdata_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [PIXEL_WIDTH*LINE_PIXELS-1:0] out_data_o,
  output logic [1:0]                      out_sel_o,
  output logic                            out_last_o
);

  localparam int unsigned DW = PIXEL_WIDTH * LINE_PIXELS;
  localparam int unsigned FW = DW + 3;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [7:0] LUMA_LAST   = 8'(LUMA_BASE + LUMA_LINES - 1);
  localparam logic [7:0] CHROMA_LAST = 8'(CHROMA_BASE + CHROMA_LINES - 1);
  localparam logic [7:0] TOP_LAST    = 8'(TOP_BASE + TOP_LINES - 1);

  state_e        state_q, state_d;
  logic [7:0]    addr_q;
  logic          top_en_q;
  logic          inflight_q;
  sel_e          inf_sel_q, sel_cur;
  logic          inf_last_q, last_cur;
  logic          ren, pop, credit_ok;
  logic [CW:0]   occ;

  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [FW-1:0] fifo_rdata;

  assign pop = out_valid_o & out_ready_i;

  // Entries held plus the read in flight, net of this cycle's pop
  always_comb begin
    occ       = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    credit_ok = (occ < (CW + 1)'(FIFO_DEPTH));
  end

  // Next-state, read issue and beat tagging
  always_comb begin
    state_d  = state_q;
    ren      = 1'b0;
    sel_cur  = SEL_LUMA;
    last_cur = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_LUMA;
      ST_LUMA: begin
        ren = credit_ok;
        if (ren && addr_q == LUMA_LAST) state_d = ST_CHROMA;
      end
      ST_CHROMA: begin
        sel_cur  = SEL_CHROMA;
        ren      = credit_ok;
        last_cur = (addr_q == CHROMA_LAST) && !top_en_q;
        if (ren && addr_q == CHROMA_LAST) state_d = top_en_q ? ST_TOP : ST_DRAIN;
      end
      ST_TOP: begin
        sel_cur  = SEL_TOP;
        ren      = credit_ok;
        last_cur = (addr_q == TOP_LAST);
        if (ren && addr_q == TOP_LAST) state_d = ST_DRAIN;
      end
      // Leave as the final beat is accepted so done follows one cycle later
      ST_DRAIN:
        if (!inflight_q && (fifo_empty || (fifo_count == CW'(1) && pop)))
          state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, address counter and read-latency tag pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      top_en_q   <= 1'b0;
      inflight_q <= 1'b0;
      inf_sel_q  <= SEL_LUMA;
      inf_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= ren;
      inf_sel_q  <= sel_cur;
      inf_last_q <= last_cur;
      if (state_q == ST_IDLE && start_i) begin
        addr_q   <= 8'(LUMA_BASE);
        top_en_q <= top_en_i;
      end else if (ren) begin
        addr_q <= addr_q + 8'd1;
      end
    end
  end

  fetch_db_skid_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .wdata_i ({inf_last_q, inf_sel_q, rdata_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign ren_o       = ren;
  assign raddr_o     = addr_q;
  assign out_valid_o = ~fifo_empty;
  assign {out_last_o, out_sel_o, out_data_o} = fifo_rdata;

endmodule

// File: tb/tb_fetch_db_line_rd.sv
// Directed bench for the deblocking line-buffer read sequencer.
module tb_fetch_db_line_rd;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         top_en_i = 1'b0;
  logic         out_ready_i = 1'b0;
  logic [255:0] rdata_i = '0;
  logic         busy_o, done_o, ren_o, out_valid_o, out_last_o;
  logic [7:0]   raddr_o;
  logic [255:0] out_data_o;
  logic [1:0]   out_sel_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_addr, issued, beat, total, dones, last_hs_cyc, first_valid_cyc, start_cyc;
  int mode = 0;
  bit done_seen, hold_v;
  logic [258:0] hold_val;

  fetch_db_line_rd #(
    .PIXEL_WIDTH (8),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .top_en_i    (top_en_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ren_o       (ren_o),
    .raddr_o     (raddr_o),
    .rdata_i     (rdata_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_sel_o   (out_sel_o),
    .out_last_o  (out_last_o)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [7:0] a);
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = a ^ 8'(i * 37);
    return v;
  endfunction

  // Buffer model: one-cycle read latency
  always @(posedge clk) if (ren_o) rdata_i <= line_of(raddr_o);

  task automatic chk(input string tag, input logic [258:0] obs, input logic [258:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_ready();
    case (mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ($urandom_range(0, 9) < 3);
      default: out_ready_i = 1'b0;
    endcase
  endtask

  // One clock: scoreboard at the falling edge, return just after the rising edge
  task automatic tick();
    bit pop;
    int exp_sel;
    @(negedge clk);
    cyc++;
    pop = out_valid_o && out_ready_i;
    if (ren_o) begin
      chki("raddr", int'(raddr_o), exp_addr);
      chki("credit_limit", int'((issued + 1 - beat - int'(pop)) <= 4), 1);
      exp_addr++;
      issued++;
    end
    if (hold_v) begin
      chki("hold_valid", int'(out_valid_o), 1);
      chk("hold_beat", {out_last_o, out_sel_o, out_data_o}, hold_val);
    end
    if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (pop) begin
      exp_sel = (beat < 128) ? 0 : (beat < 192) ? 1 : 2;
      chk("beat_data", {3'b0, out_data_o}, {3'b0, line_of(8'(beat))});
      chki("beat_sel", int'(out_sel_o), exp_sel);
      chki("beat_last", int'(out_last_o), int'(beat == total - 1));
      last_hs_cyc = cyc;
      beat++;
    end
    hold_v   = out_valid_o && !out_ready_i;
    hold_val = {out_last_o, out_sel_o, out_data_o};
    if (dut.inflight_q) chki("push_into_full", int'(dut.fifo_full && !pop), 0);
    if (done_o) begin
      dones++;
      done_seen = 1'b1;
      chki("done_beats", beat, total);
      chki("done_latency", cyc, last_hs_cyc + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic begin_lcu(input bit top, input int tot);
    exp_addr = 0; issued = 0; beat = 0; total = tot; dones = 0;
    done_seen = 1'b0; first_valid_cyc = -1; last_hs_cyc = -10;
    start_i = 1'b1;
    top_en_i = top;
    drive_ready();
    start_cyc = cyc + 1;
    tick();
    start_i = 1'b0;
    top_en_i = 1'b0;
    chki("busy_after_start", int'(busy_o), 1);
  endtask

  task automatic run(input int stop_beat, input int budget);
    int n = 0;
    while (!done_seen && beat < stop_beat && n < budget) begin
      drive_ready();
      tick();
      n++;
    end
    if (n >= budget) chki("timeout", 1, 0);
  endtask

  task automatic finish_lcu();
    run(1 << 30, 3000);
    chki("total_beats", beat, total);
    chki("total_reads", issued, total);
    chki("done_count", dones, 1);
    chki("busy_after_done", int'(busy_o), 0);
    tick();
    chki("single_done", dones, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_outs"}, {busy_o, done_o, ren_o, out_valid_o, out_last_o, out_sel_o},
        {254'b0, 5'b0});
    chki({tag, "_raddr"}, int'(raddr_o), 0);
    chk({tag, "_data"}, {3'b0, out_data_o}, '0);
  endtask

  initial begin
    hold_v = 1'b0;
    exp_addr = 0; issued = 0; beat = 0; total = 0; dones = 0;
    // Reset state
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_held");
    rst_n = 1'b1;
    tick();
    chki("idle_no_done", dones, 0);

    // Basic, no top region, full throughput
    mode = 0;
    begin_lcu(1'b0, 192);
    finish_lcu();
    chki("first_valid_latency", first_valid_cyc - start_cyc, 3);

    // Top region enabled under random backpressure
    mode = 1;
    begin_lcu(1'b1, 208);
    finish_lcu();

    // Stall mid-luma, then release
    mode = 0;
    begin_lcu(1'b0, 192);
    run(40, 500);
    mode = 2;
    repeat (20) begin
      drive_ready();
      tick();
    end
    chki("stall_ren_off", int'(ren_o), 0);
    chki("stall_outstanding", issued - beat, 4);
    chki("stall_addr_hold", int'(raddr_o), exp_addr);
    mode = 0;
    finish_lcu();

    // Start while busy is ignored
    begin_lcu(1'b0, 192);
    run(50, 500);
    start_i = 1'b1;
    top_en_i = 1'b1;
    tick();
    start_i = 1'b0;
    top_en_i = 1'b0;
    finish_lcu();

    // Asynchronous reset mid-luma, then a clean run
    begin_lcu(1'b0, 192);
    run(100, 500);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    hold_v = 1'b0;
    repeat (3) tick();
    chki("no_done_in_reset", dones, 0);
    rst_n = 1'b1;
    tick();
    chki("no_done_after_reset", dones, 0);
    begin_lcu(1'b0, 192);
    finish_lcu();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
